// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes and controller state encoding
package alu_pkg;
   localparam int ALU_DATA_W = 8;
   localparam int ALU_OP_W   = 3;
   localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [ALU_OP_W-1:0] OP_NOT = 3'b101;
   localparam logic [ALU_OP_W-1:0] OP_SHL = 3'b110;
   localparam logic [ALU_OP_W-1:0] OP_SHR = 3'b111;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;
endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: two-way round-robin picker favouring the requester not served last
module alu_rr_pick (
   input  logic [1:0] req_valid_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       any_o
);
   // both pending: alternate away from the last winner; otherwise take whoever is pending
   always_comb begin
      any_o   = |req_valid_i;
      grant_o = (&req_valid_i) ? ~last_grant_i : req_valid_i[1];
   end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters, one job in flight at a time
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W      = ALU_DATA_W,
   parameter int OP_W        = ALU_OP_W,
   parameter int ALU_LATENCY = 1
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic [1:0]        req_valid_i,
   output logic [1:0]        req_ready_o,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   input  logic [OP_W-1:0]   req0_op_i,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   input  logic [OP_W-1:0]   req1_op_i,
   output logic [1:0]        rsp_valid_o,
   input  logic [1:0]        rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              alu_enable_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [OP_W-1:0]   alu_control_bus_o,
   input  logic [DATA_W-1:0] alu_outp_i,
   output logic              busy_o
);
   localparam int CNT_W = 4;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              pick_grant;
   logic              pick_any;

   alu_rr_pick u_pick (
      .req_valid_i  (req_valid_i),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_grant),
      .any_o        (pick_any)
   );

   // job sequencing: accept in IDLE, pulse the ALU, count down its latency, hold result until taken
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      data_d       = data_q;
      req_ready_o  = 2'b00;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               req_ready_o = pick_grant ? 2'b10 : 2'b01;
               grant_d     = pick_grant;
               a_d         = pick_grant ? req1_a_i : req0_a_i;
               b_d         = pick_grant ? req1_b_i : req0_b_i;
               op_d        = pick_grant ? req1_op_i : req0_op_i;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(ALU_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               data_d  = alu_outp_i;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, arbitration history and operand/result registers; reset discards any job in flight
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         data_q       <= data_d;
      end
   end

   assign alu_enable_o      = (state_q == ISSUE);
   assign busy_o            = (state_q != IDLE);
   assign rsp_valid_o       = (state_q != RESP) ? 2'b00 : (grant_q ? 2'b10 : 2'b01);
   assign rsp_data_o        = data_q;
   assign alu_a_o           = a_q;
   assign alu_b_o           = b_q;
   assign alu_control_bus_o = op_q;
endmodule
